// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with a single outstanding memory request
//
// Purpose:
//   Fetches one instruction at a time from instruction memory and presents it
//   to decode. Only one request can be in flight. A branch redirect from decode
//   replaces the fetch PC in any state. A response that belongs to the
//   squashed path is consumed and thrown away.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   id_ready          decode can accept the presented instruction
//   br_taken          one-cycle redirect pulse from decode
//   br_target[31:0]   redirect PC, sampled with br_taken
//   to_id_valid       instruction presented to decode
//   to_id_pc[31:0]    PC of presented instruction (full 32 bits)
//   to_id_inst[31:0]  presented instruction word
//   inst_req          memory request valid
//   inst_addr[31:0]   word-aligned request address
//   inst_addr_ok      request accepted this cycle
//   inst_data_ok      read data valid this cycle
//   inst_rdata[31:0]  read data

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        to_id_valid,
  output logic [31:0] to_id_pc,
  output logic [31:0] to_id_inst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        cancel_q, cancel_d;

  // Event decodes shared by the FSM and the datapath.
  logic req_accept;   // request handed to memory this cycle
  logic resp_arrive;  // response for our outstanding request
  logic resp_drop;    // response belongs to a squashed path
  logic hold_fire;    // decode takes the presented instruction

  assign req_accept  = (state_q == S_REQ)  && inst_addr_ok;
  assign resp_arrive = (state_q == S_WAIT) && inst_data_ok;
  assign resp_drop   = resp_arrive && (cancel_q || br_taken);
  assign hold_fire   = (state_q == S_HOLD) && id_ready;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        // A request accepted alongside a redirect still occupies memory, so
        // we must wait for its response even though it will be discarded.
        if (inst_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d = (cancel_q || br_taken) ? S_REQ : S_HOLD;
        end
      end
      S_HOLD: begin
        // A redirect leaves HOLD even without id_ready; if decode also
        // handshakes in that cycle it squashes the instruction itself.
        if (br_taken || id_ready) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. Both depend only on registered state (and reset), so
  // neither id_ready nor br_taken reaches to_id_valid combinationally.
  // ---------------------------------------------------------------------
  always_comb begin
    inst_req    = 1'b0;
    to_id_valid = 1'b0;
    if (!rst) begin
      case (state_q)
        S_REQ:   inst_req    = 1'b1;
        S_HOLD:  to_id_valid = 1'b1;
        default: begin
          inst_req    = 1'b0;
          to_id_valid = 1'b0;
        end
      endcase
    end
  end

  assign inst_addr  = {fetch_pc_q[31:2], 2'b00};
  assign to_id_pc   = buf_pc_q;
  assign to_id_inst = buf_inst_q;

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    cancel_d   = cancel_q;

    // Redirect beats the sequential +4 update.
    if (br_taken) begin
      fetch_pc_d = br_target;
    end else if (hold_fire) begin
      fetch_pc_d = buf_pc_q + 32'd4;
    end

    if (req_accept) begin
      buf_pc_d = fetch_pc_q;
    end

    if (resp_arrive && !resp_drop) begin
      buf_inst_d = inst_rdata;
    end

    // cancel marks the one outstanding response as wrong-path. It is set
    // when a redirect happens while a request is (or becomes) outstanding
    // and cleared once that response has been swallowed.
    if (resp_drop) begin
      cancel_d = 1'b0;
    end else if (br_taken && (req_accept || state_q == S_WAIT)) begin
      cancel_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      buf_pc_q   <= 32'h0;
      buf_inst_q <= 32'h0;
      cancel_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      cancel_q   <= cancel_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage

module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk;
  logic        rst;
  logic        id_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        to_id_valid;
  logic [31:0] to_id_pc;
  logic [31:0] to_id_inst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  int n_cmp;
  int n_err;
  int cyc;

  logic [63:0] exp_q[$];

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_ready     (id_ready),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .to_id_valid  (to_id_valid),
    .to_id_pc     (to_id_pc),
    .to_id_inst   (to_id_inst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, cycle=%0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory-side driver: accepts the current request after aw idle cycles and
  // returns data after dw further idle cycles. Expected delivery is queued.
  task automatic fetch_drive(input logic [31:0] pc, input logic [31:0] data,
                             input int aw, input int dw, input logic deliver);
    for (int i = 0; i < aw; i++) step();
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    for (int i = 0; i < dw; i++) step();
    inst_data_ok = 1'b1;
    inst_rdata   = data;
    if (deliver) exp_q.push_back({pc, data});
    step();
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; id_ready = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    step();
    step();
    n_cmp++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", inst_req); end
    n_cmp++; if (to_id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", to_id_valid); end
    n_cmp++; if (to_id_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=00000000", to_id_pc); end
    n_cmp++; if (to_id_inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got=%h exp=00000000", to_id_inst); end
    rst = 1'b0;
    #1;
    n_cmp++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL first_req got=%b exp=1", inst_req); end
    n_cmp++; if (inst_addr !== RESET_PC) begin n_err++; $display("FAIL first_addr got=%h exp=%h", inst_addr, RESET_PC); end
  endtask

  task automatic test_basic();
    logic [63:0] e;
    id_ready = 1'b1;
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    n_cmp++; if (inst_req !== 1'b0 || to_id_valid !== 1'b0) begin n_err++; $display("FAIL basic_wait got=req%b/val%b exp=0/0", inst_req, to_id_valid); end
    inst_data_ok = 1'b1; inst_rdata = 32'h02800000;
    exp_q.push_back({RESET_PC, 32'h02800000});
    step();
    inst_data_ok = 1'b0;
    n_cmp++; if (to_id_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b exp=1", to_id_valid); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    n_cmp++; if ({to_id_pc, to_id_inst} !== e) begin n_err++; $display("FAIL basic_data got=%h exp=%h", {to_id_pc, to_id_inst}, e); end
    step();
    n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'h1c000004) begin n_err++; $display("FAIL basic_next got=%b/%h exp=1/1c000004", inst_req, inst_addr); end
  endtask

  task automatic test_stall();
    logic [63:0] e;
    id_ready = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'hbadbad00;
    step();
    inst_data_ok = 1'b0;
    n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'h1c000004 || to_id_valid !== 1'b0) begin
      n_err++; $display("FAIL stray_data_req got=%b/%h/%b exp=1/1c000004/0", inst_req, inst_addr, to_id_valid); end
    fetch_drive(32'h1c000004, 32'h11111111, 1, 2, 1'b1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    n_cmp++; if (to_id_valid !== 1'b1 || {to_id_pc, to_id_inst} !== e) begin
      n_err++; $display("FAIL stall_first got=%b/%h exp=1/%h", to_id_valid, {to_id_pc, to_id_inst}, e); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin inst_data_ok = 1'b1; inst_rdata = 32'hcafef00d; end
      step();
      inst_data_ok = 1'b0;
      n_cmp++; if (to_id_valid !== 1'b1 || inst_req !== 1'b0 || {to_id_pc, to_id_inst} !== e) begin
        n_err++; $display("FAIL stall_hold%0d got=%b/%b/%h exp=1/0/%h", i, to_id_valid, inst_req, {to_id_pc, to_id_inst}, e); end
    end
    id_ready = 1'b1;
    step();
    n_cmp++; if (to_id_valid !== 1'b0 || inst_addr !== 32'h1c000008) begin
      n_err++; $display("FAIL stall_release got=%b/%h exp=0/1c000008", to_id_valid, inst_addr); end
  endtask

  task automatic test_br_on_accept();
    inst_addr_ok = 1'b1; br_taken = 1'b1; br_target = 32'h1c000040;
    step();
    inst_addr_ok = 1'b0; br_taken = 1'b0;
    n_cmp++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL bracc_wait got=%b exp=0", inst_req); end
    inst_data_ok = 1'b1; inst_rdata = 32'hbad0bad0;
    step();
    inst_data_ok = 1'b0;
    n_cmp++; if (to_id_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1c000040) begin
      n_err++; $display("FAIL bracc_drop got=%b/%b/%h exp=0/1/1c000040", to_id_valid, inst_req, inst_addr); end
  endtask

  task automatic test_br_in_wait();
    logic [63:0] e;
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    br_taken = 1'b1; br_target = 32'h1c000100;
    step();
    br_taken = 1'b0;
    n_cmp++; if (inst_req !== 1'b0 || to_id_valid !== 1'b0) begin
      n_err++; $display("FAIL brwait_stay got=%b/%b exp=0/0", inst_req, to_id_valid); end
    step();
    inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef;
    step();
    inst_data_ok = 1'b0;
    n_cmp++; if (to_id_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1c000100) begin
      n_err++; $display("FAIL brwait_drop got=%b/%b/%h exp=0/1/1c000100", to_id_valid, inst_req, inst_addr); end
    fetch_drive(32'h1c000100, 32'h22222222, 0, 0, 1'b1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    n_cmp++; if (to_id_valid !== 1'b1 || {to_id_pc, to_id_inst} !== e) begin
      n_err++; $display("FAIL brwait_refetch got=%b/%h exp=1/%h", to_id_valid, {to_id_pc, to_id_inst}, e); end
    step();
    // branch coincident with the response: response is dropped
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h44444444; br_taken = 1'b1; br_target = 32'h1c000200;
    step();
    inst_data_ok = 1'b0; br_taken = 1'b0;
    n_cmp++; if (to_id_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1c000200) begin
      n_err++; $display("FAIL brdata_drop got=%b/%b/%h exp=0/1/1c000200", to_id_valid, inst_req, inst_addr); end
  endtask

  task automatic test_br_req_and_hold();
    logic [63:0] e;
    br_taken = 1'b1; br_target = 32'h1c000300;
    step();
    br_taken = 1'b0;
    n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'h1c000300) begin
      n_err++; $display("FAIL brreq_addr got=%b/%h exp=1/1c000300", inst_req, inst_addr); end
    id_ready = 1'b0;
    fetch_drive(32'h1c000300, 32'h55555555, 0, 1, 1'b1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    n_cmp++; if (to_id_valid !== 1'b1 || {to_id_pc, to_id_inst} !== e) begin
      n_err++; $display("FAIL brreq_fetch got=%b/%h exp=1/%h", to_id_valid, {to_id_pc, to_id_inst}, e); end
    br_taken = 1'b1; br_target = 32'h1c000400;
    step();
    br_taken = 1'b0;
    n_cmp++; if (to_id_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1c000400) begin
      n_err++; $display("FAIL brhold got=%b/%b/%h exp=0/1/1c000400", to_id_valid, inst_req, inst_addr); end
  endtask

  task automatic test_wrap_and_unaligned();
    logic [63:0] e;
    id_ready = 1'b1;
    br_taken = 1'b1; br_target = 32'hfffffffc;
    step();
    br_taken = 1'b0;
    fetch_drive(32'hfffffffc, 32'h66666666, 0, 0, 1'b1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    n_cmp++; if (to_id_valid !== 1'b1 || {to_id_pc, to_id_inst} !== e) begin
      n_err++; $display("FAIL wrap_fetch got=%b/%h exp=1/%h", to_id_valid, {to_id_pc, to_id_inst}, e); end
    step();
    n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'h00000000) begin
      n_err++; $display("FAIL wrap_next got=%b/%h exp=1/00000000", inst_req, inst_addr); end
    br_taken = 1'b1; br_target = 32'h1c000402;
    step();
    br_taken = 1'b0;
    n_cmp++; if (inst_addr !== 32'h1c000400) begin n_err++; $display("FAIL unal_addr got=%h exp=1c000400", inst_addr); end
    fetch_drive(32'h1c000402, 32'h77777777, 0, 0, 1'b1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    n_cmp++; if (to_id_valid !== 1'b1 || {to_id_pc, to_id_inst} !== e) begin
      n_err++; $display("FAIL unal_pc got=%b/%h exp=1/%h", to_id_valid, {to_id_pc, to_id_inst}, e); end
    step();
    n_cmp++; if (inst_addr !== 32'h1c000404) begin n_err++; $display("FAIL unal_next got=%h exp=1c000404", inst_addr); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    logic [31:0] pc;
    int t0;
    pc = 32'h1c000406;
    id_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      fetch_drive(pc, $urandom, 0, 0, 1'b1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      n_cmp++; if (to_id_valid !== 1'b1 || {to_id_pc, to_id_inst} !== e) begin
        n_err++; $display("FAIL b2b_data%0d got=%b/%h exp=1/%h", i, to_id_valid, {to_id_pc, to_id_inst}, e); end
      step();
      pc = pc + 32'd4;
      n_cmp++; if (inst_addr !== {pc[31:2], 2'b00} || (cyc - t0) !== 3 * (i + 1)) begin
        n_err++; $display("FAIL b2b_next%0d got=%h/%0d exp=%h/%0d", i, inst_addr, cyc - t0, {pc[31:2], 2'b00}, 3 * (i + 1)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] e;
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    rst = 1'b1;
    step();
    n_cmp++; if (inst_req !== 1'b0 || to_id_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_out got=%b/%b exp=0/0", inst_req, to_id_valid); end
    rst = 1'b0;
    #1;
    n_cmp++; if (inst_req !== 1'b1 || inst_addr !== RESET_PC) begin
      n_err++; $display("FAIL rstmid_req got=%b/%h exp=1/%h", inst_req, inst_addr, RESET_PC); end
    inst_data_ok = 1'b1; inst_rdata = 32'hfeedface;
    step();
    inst_data_ok = 1'b0;
    n_cmp++; if (inst_req !== 1'b1 || to_id_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_late got=%b/%b exp=1/0", inst_req, to_id_valid); end
    id_ready = 1'b0;
    fetch_drive(RESET_PC, 32'h88888888, 0, 0, 1'b1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    n_cmp++; if (to_id_valid !== 1'b1 || {to_id_pc, to_id_inst} !== e) begin
      n_err++; $display("FAIL rsthold_fetch got=%b/%h exp=1/%h", to_id_valid, {to_id_pc, to_id_inst}, e); end
    rst = 1'b1;
    #1;
    n_cmp++; if (to_id_valid !== 1'b0 || inst_req !== 1'b0) begin
      n_err++; $display("FAIL rsthold_out got=%b/%b exp=0/0", to_id_valid, inst_req); end
    step();
    n_cmp++; if (to_id_pc !== 32'h0 || to_id_inst !== 32'h0) begin
      n_err++; $display("FAIL rsthold_buf got=%h/%h exp=0/0", to_id_pc, to_id_inst); end
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_stall();
    test_br_on_accept();
    test_br_in_wait();
    test_br_req_and_hold();
    test_wrap_and_unaligned();
    test_back_to_back();
    test_reset_mid();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
